// File: rtl/wb_rf_writer.sv
// Writeback-side driver of the register-file write port.
// Merges the in-order MEM/WB result stream (highest priority, never back-pressured)
// with long-latency results queued in a small valid/ready FIFO. Keeps a busy
// scoreboard of registers whose long-latency result is still outstanding and
// requests a pipeline stall when the FIFO keeps losing arbitration.
module wb_rf_writer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pipe_valid,
  input  logic [4:0]  i_pipe_reg,
  input  logic [31:0] i_pipe_data,
  input  logic        i_lu_valid,
  input  logic [4:0]  i_lu_reg,
  input  logic [31:0] i_lu_data,
  output logic        o_lu_ready,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_reg,
  output logic [31:0] o_busy,
  output logic        o_pipe_stall,
  output logic        o_wr_control,
  output logic [4:0]  o_wr_reg,
  output logic [31:0] o_wr_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_reg  [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] starve_cnt;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          pipe_sel;
  logic [4:0]    head_reg;
  logic [31:0]   head_data;
  logic [31:0]   busy_next;

  // Arbitration, FIFO status and scoreboard next-state
  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    o_lu_ready   = !full && !i_rst;
    o_pipe_stall = (starve_cnt == CW'(STARVE_LIMIT));
    // A pipe write to r0 is treated as an idle slot so the FIFO can drain.
    pipe_sel     = !o_pipe_stall && i_pipe_valid && (i_pipe_reg != 5'd0);
    pop          = !pipe_sel && !empty;
    // r0 results are accepted on the handshake but never enqueued.
    push         = i_lu_valid && o_lu_ready && (i_lu_reg != 5'd0);
    head_reg     = fifo_reg[rd_ptr[AW-1:0]];
    head_data    = fifo_data[rd_ptr[AW-1:0]];
    busy_next    = o_busy;
    // Clear first so a same-cycle issue to the same register wins.
    if (pop) begin
      busy_next[head_reg] = 1'b0;
    end
    if (i_issue_valid && (i_issue_reg != 5'd0)) begin
      busy_next[i_issue_reg] = 1'b1;
    end
  end

  // FIFO storage; contents need no reset since pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_reg[wr_ptr[AW-1:0]]  <= i_lu_reg;
      fifo_data[wr_ptr[AW-1:0]] <= i_lu_data;
    end
  end

  // Pointers, starve counter, scoreboard and registered write port
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      starve_cnt   <= '0;
      o_busy       <= '0;
      o_wr_control <= 1'b0;
      o_wr_reg     <= '0;
      o_wr_data    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop || empty) begin
        starve_cnt <= '0;
      end else if (pipe_sel) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
      o_busy <= busy_next;
      if (pipe_sel) begin
        o_wr_control <= 1'b1;
        o_wr_reg     <= i_pipe_reg;
        o_wr_data    <= i_pipe_data;
      end else if (pop) begin
        o_wr_control <= 1'b1;
        o_wr_reg     <= head_reg;
        o_wr_data    <= head_data;
      end else begin
        o_wr_control <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_rf_writer.sv
// Directed bench for wb_rf_writer with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_wb_rf_writer;

  logic        clk;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_reg;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [31:0] busy;
  logic        pipe_stall;
  logic        wr_control;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  wb_rf_writer #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pipe_valid  (pipe_valid),
    .i_pipe_reg    (pipe_reg),
    .i_pipe_data   (pipe_data),
    .i_lu_valid    (lu_valid),
    .i_lu_reg      (lu_reg),
    .i_lu_data     (lu_data),
    .o_lu_ready    (lu_ready),
    .i_issue_valid (issue_valid),
    .i_issue_reg   (issue_reg),
    .o_busy        (busy),
    .o_pipe_stall  (pipe_stall),
    .o_wr_control  (wr_control),
    .o_wr_reg      (wr_reg),
    .o_wr_data     (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_valid  = 1'b0;
    pipe_reg    = '0;
    pipe_data   = '0;
    lu_valid    = 1'b0;
    lu_reg      = '0;
    lu_data     = '0;
    issue_valid = 1'b0;
    issue_reg   = '0;
  endtask

  task automatic drive_pipe(input logic [4:0] r, input logic [31:0] d);
    pipe_valid = 1'b1;
    pipe_reg   = r;
    pipe_data  = d;
  endtask

  task automatic drive_lu(input logic [4:0] r, input logic [31:0] d);
    lu_valid = 1'b1;
    lu_reg   = r;
    lu_data  = d;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    // reset state
    check("rst_ready", {31'd0, lu_ready}, 32'd0);
    check("rst_wr_ctl", {31'd0, wr_control}, 32'd0);
    check("rst_wr_reg", {27'd0, wr_reg}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_stall", {31'd0, pipe_stall}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, lu_ready}, 32'd1);

    // 1: plain pipe write
    drive_pipe(5'd5, 32'hDEADBEEF);
    step();
    idle();
    check("t1_ctl", {31'd0, wr_control}, 32'd1);
    check("t1_reg", {27'd0, wr_reg}, 32'd5);
    check("t1_data", wr_data, 32'hDEADBEEF);
    step();
    check("t1_idle_ctl", {31'd0, wr_control}, 32'd0);

    // 2: issue, long-latency return, scoreboard clear
    issue_valid = 1'b1;
    issue_reg   = 5'd3;
    step();
    idle();
    check("t2_busy_set", busy, 32'h0000_0008);
    drive_lu(5'd3, 32'h12345678);
    step();
    idle();
    check("t2_no_wr_yet", {31'd0, wr_control}, 32'd0);
    check("t2_busy_hold", busy, 32'h0000_0008);
    step();
    check("t2_ctl", {31'd0, wr_control}, 32'd1);
    check("t2_reg", {27'd0, wr_reg}, 32'd3);
    check("t2_data", wr_data, 32'h12345678);
    check("t2_busy_clr", busy, 32'd0);
    step();
    check("t2_idle_ctl", {31'd0, wr_control}, 32'd0);

    // 3/4: pipe every cycle, fill FIFO, starvation stall
    for (int unsigned k = 0; k < 4; k++) begin
      drive_pipe(5'(10 + k), 32'hA000_0000 + k);
      drive_lu(5'(1 + k), 32'hC000_0000 + k);
      check($sformatf("t3_ready_%0d", k), {31'd0, lu_ready}, 32'd1);
      step();
      check($sformatf("t3_pipe_reg_%0d", k), {27'd0, wr_reg}, 32'(10 + k));
    end
    lu_valid = 1'b0;
    #1;
    check("t3_full_ready", {31'd0, lu_ready}, 32'd0);
    // losses so far: cycles after pushes 1..3 -> 3; five more before stall
    for (int unsigned k = 4; k < 9; k++) begin
      drive_pipe(5'(10 + k), 32'hA000_0000 + k);
      #1;
      check($sformatf("t4_nostall_%0d", k), {31'd0, pipe_stall}, 32'd0);
      step();
      check($sformatf("t4_pipe_data_%0d", k), wr_data, 32'hA000_0000 + k);
    end
    drive_pipe(5'd20, 32'h0BAD_0BAD);
    #1;
    check("t4_stall", {31'd0, pipe_stall}, 32'd1);
    step();
    check("t4_pop_ctl", {31'd0, wr_control}, 32'd1);
    check("t4_pop_reg", {27'd0, wr_reg}, 32'd1);
    check("t4_pop_data", wr_data, 32'hC000_0000);
    check("t4_stall_clr", {31'd0, pipe_stall}, 32'd0);
    check("t4_ready_back", {31'd0, lu_ready}, 32'd1);
    idle();
    for (int unsigned k = 1; k < 4; k++) begin
      step();
      check($sformatf("t3_drain_reg_%0d", k), {27'd0, wr_reg}, 32'(1 + k));
      check($sformatf("t3_drain_data_%0d", k), wr_data, 32'hC000_0000 + k);
    end
    step();
    check("t3_drained", {31'd0, wr_control}, 32'd0);

    // 5: r0 from both sources
    drive_pipe(5'd0, 32'h1111_1111);
    drive_lu(5'd0, 32'h2222_2222);
    #1;
    check("t5_ready_pre", {31'd0, lu_ready}, 32'd1);
    step();
    idle();
    check("t5_no_wr", {31'd0, wr_control}, 32'd0);
    check("t5_ready_post", {31'd0, lu_ready}, 32'd1);
    step();
    check("t5_no_drain", {31'd0, wr_control}, 32'd0);

    // 6: reset with queued entries and pending busy bit
    issue_valid = 1'b1;
    issue_reg   = 5'd7;
    for (int unsigned k = 0; k < 3; k++) begin
      drive_pipe(5'(11 + k), 32'hB000_0000 + k);
      drive_lu(5'(8 + k), 32'hE000_0000 + k);
      step();
      issue_valid = 1'b0;
    end
    idle();
    check("t6_busy_pre", busy, 32'h0000_0080);
    rst = 1'b1;
    #1;
    check("t6_ready_rst", {31'd0, lu_ready}, 32'd0);
    step();
    check("t6_ctl_rst", {31'd0, wr_control}, 32'd0);
    check("t6_busy_rst", busy, 32'd0);
    rst = 1'b0;
    #1;
    check("t6_ready_rel", {31'd0, lu_ready}, 32'd1);
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      check($sformatf("t6_no_stale_%0d", k), {31'd0, wr_control}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
